// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI master transfer block.
//   SPI_WORD_W       : frame length in bits (one word per chip-select frame)
//   SPI_BIT_CNT_W    : width of the sclk-rise counter; holds 0..SPI_WORD_W without wrapping
//   SPI_CLK_DIV_DEF  : default clk cycles per sclk half-period
//   SPI_CS_GAP_DEF   : default clk cycles of cs high between frames
//   spi_state_e      : transfer FSM states
//   spi_frame_t      : per-frame shift registers and rise counter
package spi_pkg;

  localparam int SPI_WORD_W      = 32;
  localparam int SPI_BIT_CNT_W   = 6;
  localparam int SPI_CLK_DIV_DEF = 4;
  localparam int SPI_CS_GAP_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } spi_state_e;

  typedef struct packed {
    logic [SPI_WORD_W-1:0]    tx_shift;  // word being sent, indexed by rise count
    logic [SPI_WORD_W-1:0]    rx_shift;  // miso bits, shifted in from the top
    logic [SPI_BIT_CNT_W-1:0] rise_cnt;  // sclk rises issued so far this frame
  } spi_frame_t;

endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div -- phase timer for the SPI master.
// Emits a one-clk tick on the last cycle of every CLK_DIV-cycle period.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   clr        : hold the count at zero (period restarts when clr drops)
//   tick       : high for one cycle at the end of each period
module spi_sclk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_sclk_div: CLK_DIV must be >= 2");
  end

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Wrapping on the tick doubles as the restart at every FSM transition,
  // since transitions only ever happen on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clr || cnt == CNT_MAX)  cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_MAX) && !clr;

endmodule

// File: rtl/spi_master_xfer.sv
// spi_master_xfer -- 32-bit SPI mode-0 master, LSB first, one word per frame.
// Ports:
//   clk, rst_n          : system clock, async active-low reset
//   tx_data/tx_valid    : word to send; accepted when tx_valid && tx_ready
//   tx_ready            : high only in IDLE
//   rx_data/rx_valid    : word received in the last frame; rx_valid pulses once
//   busy                : accept cycle through end of the inter-frame gap
//   cs, sclk, mosi, miso: SPI pins (cs active low, sclk idles low)
// Frame: SETUP, 32 x (SCK_HI, SCK_LO), HOLD, each CLK_DIV cycles, so cs is
// low for 66*CLK_DIV cycles; then CS_GAP cycles of GAP and one IDLE cycle.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF,
  parameter int CS_GAP  = SPI_CS_GAP_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  cs,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_master_xfer: CLK_DIV must be >= 2");
  end
  if (CS_GAP < 1) begin : g_bad_gap
    $error("spi_master_xfer: CS_GAP must be >= 1");
  end

  localparam int                      GW        = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0]           GAP_MAX   = GW'(CS_GAP - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] LAST_RISE = SPI_BIT_CNT_W'(SPI_WORD_W);

  spi_state_e    state;
  spi_frame_t    frm;
  logic [GW-1:0] gap_cnt;
  logic          tick;
  logic          div_clr;

  // Divider only runs in the timed states; IDLE and GAP are counted elsewhere.
  assign div_clr = (state == IDLE) || (state == GAP);

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cs       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      frm      <= '0;
      gap_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state        <= SETUP;
            cs           <= 1'b0;
            mosi         <= tx_data[0];
            tx_ready     <= 1'b0;
            busy         <= 1'b1;
            frm.tx_shift <= tx_data;
            frm.rise_cnt <= '0;
          end
        end

        // SETUP and SCK_LO share the rising-edge action; SCK_LO leaves for
        // HOLD once all 32 rises are done (counter stops at 32, no wrap).
        SETUP, SCK_LO: begin
          if (tick) begin
            if (state == SCK_LO && frm.rise_cnt == LAST_RISE) begin
              state <= HOLD;
            end else begin
              state        <= SCK_HI;
              sclk         <= 1'b1;
              frm.rx_shift <= {miso, frm.rx_shift[SPI_WORD_W-1:1]};
              frm.rise_cnt <= frm.rise_cnt + 1'b1;
            end
          end
        end

        // Falling edge: rise_cnt already equals the index of the next bit.
        SCK_HI: begin
          if (tick) begin
            state <= SCK_LO;
            sclk  <= 1'b0;
            if (frm.rise_cnt != LAST_RISE)
              mosi <= frm.tx_shift[frm.rise_cnt[4:0]];
          end
        end

        HOLD: begin
          if (tick) begin
            state    <= GAP;
            cs       <= 1'b1;
            mosi     <= 1'b0;
            rx_data  <= frm.rx_shift;
            rx_valid <= 1'b1;
            gap_cnt  <= '0;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_MAX) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer (CLK_DIV=4, CS_GAP=4): a vector table of
// single frames plus hand-written back-to-back, busy-drop and mid-frame
// reset sequences. A negedge monitor tracks cs/sclk/mosi protocol.
module tb_spi_master_xfer;
  import spi_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;
  localparam int CS_LOW  = 66 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, rx_valid, busy, cs, sclk, mosi, miso;
  logic [31:0] rx_data;
  logic [1:0]  miso_mode = 2'd0;  // 0 loopback, 1 tied high, 2 tied low

  always #5 clk = ~clk;

  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? 1'b1 : 1'b0;

  spi_master_xfer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- protocol monitor ----------------
  int          cs_low_cyc = 0, last_cs_low = 0, cs_high_cyc = 0;
  int          rises = 0, rxv_cyc = 0, frames = 0, proto_err = 0, mosi_hi = 0;
  logic [31:0] mon_mosi = '0;
  int          gap_q[$];
  logic [31:0] rx_q[$];

  initial begin
    logic p_sclk, p_cs, p_mosi;
    p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0;
    forever begin
      @(negedge clk);
      if (cs == 1'b0) begin
        if (p_cs) begin
          frames++;
          gap_q.push_back(cs_high_cyc);
          cs_low_cyc = 0; rises = 0; mon_mosi = '0; mosi_hi = 0;
        end
        cs_low_cyc++;
        if (mosi) mosi_hi++;
      end else begin
        if (!p_cs) begin
          last_cs_low = cs_low_cyc;
          cs_high_cyc = 0;
        end
        cs_high_cyc++;
        if (sclk) proto_err++;
      end
      if (sclk && !p_sclk) begin
        if (rises < 32) mon_mosi[rises] = mosi;
        rises++;
      end
      if (sclk && p_sclk && mosi !== p_mosi) proto_err++;
      if (rx_valid) begin
        rxv_cyc++;
        rx_q.push_back(rx_data);
      end
      p_sclk = sclk; p_cs = cs; p_mosi = mosi;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    if (!tx_ready) chk({tag, "_ready_timeout"}, 32'(tx_ready), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] w, input logic [1:0] mode,
                           input logic [31:0] exp_rx, input string tag);
    int b_rxv, b_frm;
    miso_mode = mode;
    wait_ready(tag);
    b_rxv = rxv_cyc; b_frm = frames;
    tx_data = w; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
    wait_idle(tag);
    chk({tag, "_rx_data"},   rx_data, exp_rx);
    chk({tag, "_rxv_cyc"},   32'(rxv_cyc - b_rxv), 32'd1);
    chk({tag, "_frames"},    32'(frames - b_frm), 32'd1);
    chk({tag, "_cs_low"},    32'(last_cs_low), 32'(CS_LOW));
    chk({tag, "_rises"},     32'(rises), 32'd32);
    chk({tag, "_mosi_bits"}, mon_mosi, w);
    chk({tag, "_proto"},     32'(proto_err), 32'd0);
    if (w == 32'd0) chk({tag, "_mosi_quiet"}, 32'(mosi_hi), 32'd0);
  endtask

  typedef struct {
    logic [31:0] tx;
    logic [1:0]  mode;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b_rxv, b_frm, n, qs;

    vecs[0] = '{32'hA5A5_0F0F, 2'd0, 32'hA5A5_0F0F};
    vecs[1] = '{32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
    vecs[2] = '{32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
    vecs[3] = '{32'h8000_0001, 2'd0, 32'h8000_0001};
    vecs[4] = '{32'h1234_5678, 2'd1, 32'hFFFF_FFFF};

    // reset state
    #12;
    chk("rst_cs",       32'(cs), 32'd1);
    chk("rst_sclk",     32'(sclk), 32'd0);
    chk("rst_mosi",     32'(mosi), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  rx_data, 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // table of single frames; the first accept is the first edge after release
    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].tx, vecs[i].mode, vecs[i].exp_rx, $sformatf("vec%0d", i));

    // back-to-back with tx_valid held high
    miso_mode = 2'd0;
    wait_ready("b2b");
    b_frm = frames;
    tx_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tx_data = 32'(k);
      n = 0;
      while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    wait_idle("b2b");
    chk("b2b_frames", 32'(frames - b_frm), 32'd3);
    qs = rx_q.size();
    if (qs >= 3) begin
      chk("b2b_rx0", rx_q[qs-3], 32'd1);
      chk("b2b_rx1", rx_q[qs-2], 32'd2);
      chk("b2b_rx2", rx_q[qs-1], 32'd3);
    end else chk("b2b_rxq_size", 32'(qs), 32'd3);
    qs = gap_q.size();
    if (qs >= 2) begin
      chk("b2b_gap01", 32'(gap_q[qs-2]), 32'(CS_GAP + 1));
      chk("b2b_gap12", 32'(gap_q[qs-1]), 32'(CS_GAP + 1));
    end else chk("b2b_gapq_size", 32'(qs), 32'd2);
    chk("b2b_proto", 32'(proto_err), 32'd0);

    // word offered while busy is dropped
    wait_ready("drop");
    b_rxv = rxv_cyc; b_frm = frames;
    tx_data = 32'h0000_00FF; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("drop_busy",     32'(busy), 32'd1);
    chk("drop_tx_ready", 32'(tx_ready), 32'd0);
    tx_data = 32'hDEAD_BEEF; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_idle("drop");
    repeat (300) @(negedge clk);
    chk("drop_frames",  32'(frames - b_frm), 32'd1);
    chk("drop_rxv",     32'(rxv_cyc - b_rxv), 32'd1);
    chk("drop_rx_data", rx_data, 32'h0000_00FF);

    // reset after the 10th sclk rise aborts the frame
    wait_ready("abort");
    b_rxv = rxv_cyc;
    tx_data = 32'hCAFE_F00D; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    while (rises < 10 && n < 2000) begin @(negedge clk); n++; end
    chk("abort_rises", 32'(rises), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs",       32'(cs), 32'd1);
    chk("abort_sclk",     32'(sclk), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_rx_data",  rx_data, 32'd0);
    chk("abort_busy",     32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_no_rxv",  32'(rxv_cyc - b_rxv), 32'd0);
    chk("abort_rx_hold", rx_data, 32'd0);
    run_frame(32'h1357_9BDF, 2'd0, 32'h1357_9BDF, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_xfer.md
SPI_MASTER_XFER -- requirements
Module: spi_master_xfer

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4: clk cycles per sclk half-period; legal range >=2.
REQ-002 SHALL provide parameter CS_GAP, default 4: minimum clk cycles cs is held high between frames; legal range >=1.
REQ-003 clk  in  1  system clock; the block has one clock, and all logic runs on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 tx_data  in  32  word to transmit; sampled on the accept cycle.
REQ-006 tx_valid  in  1  transmit request.
REQ-007 tx_ready  out  1  block able to accept a word.
REQ-008 rx_data  out  32  word received on miso during the last completed frame.
REQ-009 rx_valid  out  1  one-cycle pulse; rx_data is updated.
REQ-010 busy  out  1  high from the accept cycle until the end of the CS_GAP period.
REQ-011 cs  out  1  chip select, active low.
REQ-012 sclk  out  1  serial clock; idle low.
REQ-013 mosi  out  1  serial data to slave.
REQ-014 miso  in  1  serial data from slave.

Function
REQ-015 SHALL use SPI mode 0: the slave samples mosi on sclk rising edges; the master samples miso on sclk rising edges; mosi changes only on sclk falling edges or at frame start.
REQ-016 SHALL shift bits LSB first: bit i travels on the i-th sclk rise (i = 0..31) for both mosi and miso.
REQ-017 SHALL accept a word on any clk edge where tx_valid=1 and tx_ready=1; a word offered while tx_ready=0 SHALL be ignored.
REQ-018 SHALL use FSM states IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP.
REQ-019 IDLE: tx_ready=1. On accept -> SETUP; in that cycle cs drives 0, mosi drives tx_data[0], and sclk stays 0.
REQ-020 SETUP: after CLK_DIV cycles -> SCK_HI; sclk drives 1 and miso is sampled into rx_shift[0].
REQ-021 SCK_HI: after CLK_DIV cycles -> SCK_LO; sclk drives 0; if bits remain, mosi drives the next bit.
REQ-022 SCK_LO: after CLK_DIV cycles, if fewer than 32 rises have occurred -> SCK_HI (sample the next bit); otherwise -> HOLD.
REQ-023 HOLD: after CLK_DIV cycles -> GAP; cs drives 1, rx_data takes rx_shift, and rx_valid pulses for exactly this cycle.
REQ-024 GAP: cs stays 1 for CS_GAP cycles -> IDLE; tx_ready=0 throughout GAP.
REQ-025 Frame timing: cs is low for exactly 66*CLK_DIV clk cycles, and each frame has exactly 32 sclk rising edges.
REQ-026 The bit counter SHALL be 6 bits wide and SHALL NOT wrap mid-frame.
REQ-027 The divider counter SHALL restart at each state transition.
REQ-028 rx_valid has no backpressure; rx_data SHALL hold its value until the next frame completes.
REQ-029 Back-to-back operation: tx_valid held high SHALL produce frames separated by exactly CS_GAP cycles of cs high plus one IDLE accept cycle.
REQ-030 miso SHALL be sampled as-is; X/Z values propagate into rx_data and are not filtered.
REQ-031 A CLK_DIV<2 or CS_GAP<1 value SHALL cause an elaboration-time error.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, cs=1, sclk=0, mosi=0, tx_ready=1 (after release), busy=0, rx_valid=0, rx_data=0, all counters 0.
REQ-033 Reset mid-frame SHALL abort the frame immediately: cs rises and sclk falls in the same instant, and no rx_valid is generated.
REQ-034 The first accept after rst_n release SHALL be possible on the first clk edge where tx_valid=1.

Structure
REQ-035 Package spi_pkg SHALL hold: constant SPI_WORD_W=32, the FSM state enum, and the default values for CLK_DIV and CS_GAP.
REQ-036 Sub-module spi_sclk_div SHALL generate a one-clk tick every CLK_DIV cycles, restartable by a clear input; all other logic stays in spi_master_xfer.

Verification
REQ-037 Loopback (miso tied to mosi), CLK_DIV=4, tx_data=32'hA5A5_0F0F -> rx_data=32'hA5A5_0F0F, one rx_valid pulse, cs low for 264 cycles.
REQ-038 miso tied to 1, tx_data=0 -> rx_data=32'hFFFF_FFFF; mosi stays 0 for the whole frame; exactly 32 sclk rises observed.
REQ-039 tx_valid held high with words 1, 2, 3 in loopback -> three frames, each cs high gap = CS_GAP+1 cycles, rx_data sequence 1, 2, 3.
REQ-040 tx_valid pulsed while busy=1 -> word ignored; no extra frame; tx_ready=0 during that cycle.
REQ-041 rst_n asserted after the 10th sclk rise -> cs=1 and sclk=0 immediately, no rx_valid, rx_data=0; next frame after reset completes correctly.
REQ-042 Protocol checker on all runs: mosi stable while sclk high, sclk low whenever cs=1, MSB last / LSB first order verified against tx_data.
